// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the I/D memory-port arbiter: FSM state encoding,
//   owner encoding and default address/data widths.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    // Owner encoding, also used for the round-robin "last granted" bit
    localparam logic OWN_SEL_I = 1'b0;
    localparam logic OWN_SEL_D = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OWN_I  = 3'd1,
        ST_OWN_D  = 3'd2,
        ST_HOLD_I = 3'd3,
        ST_HOLD_D = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2
//   Two-input round-robin picker, purely combinational.
//   req_i / req_d : requests from I-cache / D-cache
//   last          : who was granted last (0 = I, 1 = D)
//   gnt_i / gnt_d : one-hot (or zero) grant
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last,
    output logic gnt_i,
    output logic gnt_d
);

    // On a tie the side that was not granted last wins
    assign gnt_i = req_i & (~req_d | (last == OWN_SEL_D));
    assign gnt_d = req_d & (~req_i | (last == OWN_SEL_I));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one line-granular memory port between the I-cache and D-cache.
//   Grants one requester at a time (round-robin on ties, zero added latency
//   from IDLE), routes mem_ready/mem_rdata back to the owner only, and holds
//   read data one extra cycle because the caches register mem_ready and
//   consume rdata a cycle later.
//   Ports:
//     clk, proc_reset_n           : clock, synchronous active-low reset
//     i_mem_*                     : I-cache read interface
//     d_mem_*                     : D-cache read / write-back interface
//     mem_*                       : shared memory port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int D_FIRST = 1
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t        r_state;
    logic              r_last;
    logic [DATA_W-1:0] r_rdata_buf;

    logic w_req_d;
    logic w_gnt_i;
    logic w_gnt_d;
    logic w_sel_i;
    logic w_sel_d;

    // A read+write from D at once is forwarded as-is; not ours to fix
    assign w_req_d = d_mem_read | d_mem_write;

    rr_arb2 u_rr_arb2 (
        .req_i (i_mem_read),
        .req_d (w_req_d),
        .last  (r_last),
        .gnt_i (w_gnt_i),
        .gnt_d (w_gnt_d)
    );

    // Memory port source: the new winner while IDLE, else the current owner.
    // HOLD selects nobody, so memory sees an idle cycle.
    assign w_sel_i = ((r_state == ST_IDLE) & w_gnt_i) | (r_state == ST_OWN_I);
    assign w_sel_d = ((r_state == ST_IDLE) & w_gnt_d) | (r_state == ST_OWN_D);

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_sel_i) begin
            mem_read = i_mem_read;
            mem_addr = i_mem_addr;
        end else if (w_sel_d) begin
            mem_read  = d_mem_read;
            mem_write = d_mem_write;
            mem_addr  = d_mem_addr;
            mem_wdata = d_mem_wdata;
        end
    end

    // Completion goes to the owner only; rdata otherwise shows the held
    // copy so a cache acting on a registered ready still sees valid data.
    assign i_mem_ready = (r_state == ST_OWN_I) & mem_ready;
    assign d_mem_ready = (r_state == ST_OWN_D) & mem_ready;
    assign i_mem_rdata = i_mem_ready ? mem_rdata : r_rdata_buf;
    assign d_mem_rdata = d_mem_ready ? mem_rdata : r_rdata_buf;

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            // Abandons any in-flight access; caches share this reset
            r_state     <= ST_IDLE;
            r_last      <= (D_FIRST == 0) ? OWN_SEL_D : OWN_SEL_I;
            r_rdata_buf <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_i) begin
                        r_state <= ST_OWN_I;
                        r_last  <= OWN_SEL_I;
                    end else if (w_gnt_d) begin
                        r_state <= ST_OWN_D;
                        r_last  <= OWN_SEL_D;
                    end
                end
                // Stay until memory completes, even if the owner drops its
                // request: the access has already been issued.
                ST_OWN_I: begin
                    if (mem_ready) begin
                        r_rdata_buf <= mem_rdata;
                        r_state     <= ST_HOLD_I;
                    end
                end
                ST_OWN_D: begin
                    if (mem_ready) begin
                        r_rdata_buf <= mem_rdata;
                        r_state     <= ST_HOLD_D;
                    end
                end
                ST_HOLD_I,
                ST_HOLD_D: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one line-granular memory port between the I-cache and the D-cache (L1 or L2) miss/write-back interfaces.
- Grants one requester at a time and forwards its read/write, 28-bit line address and 128-bit write data to memory.
- Routes mem_ready and read data back to the owner only.
- Holds read data for one extra cycle, because both caches sample mem_ready through a register and consume mem_rdata one cycle after mem_ready.

Parameters:
- ADDR_W, 28, line address width
- DATA_W, 128, line width
- D_FIRST, 1, on a simultaneous request with no history, 1 grants D first, 0 grants I first

Ports:
- clk  in  1  clock
- proc_reset_n  in  1  synchronous, active-low reset
- i_mem_read  in  1  I-cache read request
- i_mem_addr  in  ADDR_W  I-cache line address
- i_mem_rdata  out  DATA_W  read data to I-cache
- i_mem_ready  out  1  completion to I-cache
- d_mem_read  in  1  D-cache read request
- d_mem_write  in  1  D-cache write-back request
- d_mem_addr  in  ADDR_W  D-cache line address
- d_mem_wdata  in  DATA_W  D-cache write data
- d_mem_rdata  out  DATA_W  read data to D-cache
- d_mem_ready  out  1  completion to D-cache
- mem_read  out  1  to memory
- mem_write  out  1  to memory
- mem_addr  out  ADDR_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_rdata  in  DATA_W  from memory
- mem_ready  in  1  one-cycle completion pulse from memory

Behaviour:
- States: IDLE, OWN_I, OWN_D, HOLD_I, HOLD_D. Registers: state, last (0=I, 1=D), rdata_buf.
- Reset (proc_reset_n=0 at posedge): state=IDLE, last=~D_FIRST, rdata_buf=0. All outputs are 0 while in IDLE with no request.
- Reset takes effect mid-transaction as well. The arbiter returns to IDLE and an in-flight memory access is abandoned; the caches are reset by the same signal.
- IDLE, combinational grant in the same cycle (zero added latency):
  - Only one requester active: that requester wins.
  - Both active: the requester that was not granted last wins (round-robin on last).
  - The winner's signals go to memory this cycle. next_state=OWN_x, last<=x.
- Request active for D: d_mem_read|d_mem_write. If both read and write are asserted, forward both unchanged; this is the cache's error and the arbiter does not resolve it.
- OWN_x:
  - Memory signals follow requester x combinationally.
  - The loser's signals are ignored, and its ready and rdata stay 0/held.
  - On mem_ready=1: x_mem_ready=1, x_mem_rdata=mem_rdata, rdata_buf<=mem_rdata, next_state=HOLD_x.
- HOLD_x (exactly 1 cycle):
  - mem_read=mem_write=0.
  - x_mem_rdata=rdata_buf, x_mem_ready=0.
  - next_state=IDLE. Arbitration resumes the following cycle, where a fresh request from x (e.g. the D-cache refill after a dirty write-back) competes under round-robin.
- x_mem_rdata holds rdata_buf whenever x is not receiving a mem_ready, so a cache that registers mem_ready sees valid data one cycle later.
- Non-owner ready is always 0.
- If the owner drops its request before mem_ready, the arbiter still waits in OWN_x for mem_ready; memory has already been issued.
- No request in IDLE: memory outputs are 0 and the state stays IDLE.
- Fairness: under continuous requests from both sides, grants alternate I, D, I, D. Worst-case wait is one full transaction plus one HOLD cycle.

Decomposition:
- Shared package: state encodings (IDLE..HOLD_D), owner encoding (OWN_SEL_I=0, OWN_SEL_D=1), ADDR_W/DATA_W defaults.
- One natural sub-module: rr_arb2. It is a 2-input round-robin picker with inputs req_i, req_d, last and outputs gnt_i, gnt_d; it is purely combinational.
- FSM, muxing and rdata_buf stay in mem_arbiter.

Test Plan:
- I-only read, addr 0x0000123, memory ready after 4 cycles with rdata=0xA5..A5:
  - mem_read=1 and mem_addr=0x0000123 in the request cycle.
  - i_mem_ready pulses once.
  - i_mem_rdata=0xA5..A5 on the pulse cycle and the next cycle.
  - d_mem_ready stays 0 throughout.
- Simultaneous I read 0x10 and D read 0x20 after reset with D_FIRST=1:
  - D is granted first (mem_addr=0x20).
  - After D's mem_ready plus 1 HOLD cycle, mem_addr=0x10 for I.
- D dirty miss sequence, write 0x55 data=0xDEAD.. then read 0x66:
  - mem_write=1 with mem_wdata=0xDEAD..; mem_ready ends the write.
  - One HOLD cycle with mem_read=mem_write=0.
  - Then mem_read=1 with mem_addr=0x66 if I is idle.
  - If I is requesting, I is served first, then D's read.
- Both requesting continuously for 4 transactions -> grant order alternates D, I, D, I; no requester gets two consecutive grants while the other waits.
- Reset asserted (proc_reset_n=0) in OWN_D before mem_ready -> the next cycle is IDLE with all memory outputs 0; a later stray mem_ready produces no ready to either cache.
- Owner drops d_mem_read mid-OWN_D -> the state remains OWN_D until mem_ready, and the completion is still reported on d_mem_ready.
